// File: rtl/ram_port_arbiter.sv
`timescale 1ns/1ps
// Shares the single-port program RAM between the boot loader (B) and the core (C):
// one registered RAM command per ce cycle, C > B with a starvation guard, B-only in boot mode.
module ram_port_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              boot,
  input  logic              b_req,
  input  logic              b_rw,
  input  logic [ADDR_W-1:0] b_adr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  input  logic              c_req,
  input  logic              c_rw,
  input  logic [ADDR_W-1:0] c_adr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_enable,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS_B = 2'd1,
    ACCESS_C = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t              r_state;
  state_t              w_next;
  logic                w_guard;
  logic                w_rd_tag;
  logic [7:0]          r_hold_cnt;
  logic [RD_LAT-1:0]   r_tag_vld;
  logic [RD_LAT-1:0]   r_tag_c;
  logic                r_b_rvalid;
  logic                r_c_rvalid;
  logic                r_ram_rw;
  logic [ADDR_W-1:0]   r_ram_adr;
  logic [DATA_W-1:0]   r_ram_in;

  // B overrides C once C has been granted MAX_HOLD times in a row while B waited
  always_comb begin
    w_guard  = b_req && (r_hold_cnt == HOLD_MAX);
    w_next   = IDLE;
    if (boot) begin
      if (b_req) w_next = ACCESS_B;
    end else if (c_req && !w_guard) begin
      w_next = ACCESS_C;
    end else if (b_req) begin
      w_next = ACCESS_B;
    end
    w_rd_tag = ((w_next == ACCESS_B) && !b_rw) || ((w_next == ACCESS_C) && !c_rw);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_tag_vld  <= '0;
      r_tag_c    <= '0;
      r_b_rvalid <= 1'b0;
      r_c_rvalid <= 1'b0;
      r_ram_rw   <= 1'b0;
      r_ram_adr  <= '0;
      r_ram_in   <= '0;
    end else if (ce) begin
      r_state <= w_next;
      case (w_next)
        ACCESS_B: begin
          r_ram_rw  <= b_rw;
          r_ram_adr <= b_adr;
          r_ram_in  <= b_wdata;
        end
        ACCESS_C: begin
          r_ram_rw  <= c_rw;
          r_ram_adr <= c_adr;
          r_ram_in  <= c_wdata;
        end
        default: ;
      endcase

      if ((w_next == ACCESS_B) || !b_req) begin
        r_hold_cnt <= '0;
      end else if ((w_next == ACCESS_C) && (r_hold_cnt != HOLD_MAX)) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end

      // Read tags ride alongside the RAM pipeline so each strobe returns to its issuer
      r_tag_vld[0] <= w_rd_tag;
      r_tag_c[0]   <= (w_next == ACCESS_C);
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_c[i]   <= r_tag_c[i-1];
      end
      r_b_rvalid <= r_tag_vld[RD_LAT-1] && !r_tag_c[RD_LAT-1];
      r_c_rvalid <= r_tag_vld[RD_LAT-1] &&  r_tag_c[RD_LAT-1];
    end
  end

  assign b_gnt      = (r_state == ACCESS_B);
  assign c_gnt      = (r_state == ACCESS_C);
  assign ram_enable = (r_state != IDLE);
  assign ram_rw     = r_ram_rw;
  assign ram_adr    = r_ram_adr;
  assign ram_in     = r_ram_in;
  assign b_rvalid   = r_b_rvalid;
  assign c_rvalid   = r_c_rvalid;
  assign rdata      = ram_out;

endmodule
